irrigation_timer: RTL

- Countdown controller for one irrigation cycle.
- Accepts a watering duration as four BCD digits in MM:SS form, the same digit format the clock chain produces. Counts it down to 00:00 on a 1 Hz tick while holding the valve output open.
- Exports the remaining time for the display path.
- Sits downstream of the minutes/seconds digit counters and the one-second tick generator, and directly drives the valve/pump enable.

---
 rtl/irrigation_pkg.sv | 28 ++
 rtl/bcd_down_digit.sv | 41 ++++
 rtl/irrigation_timer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/irrigation_pkg.sv
// Shared types and helpers for the irrigation countdown controller.
//   - state_t      : controller state enumeration
//   - bcd_t        : one BCD digit
//   - BCD_MAX_UNIT : highest units digit (9)
//   - BCD_MAX_TENS : highest tens-of-seconds digit (5)
//   - bcd_ok()     : digit range check against an upper limit
package irrigation_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX_UNIT = 4'd9;
  localparam bcd_t BCD_MAX_TENS = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // True when digit d lies within 0..lim.
  function automatic logic bcd_ok(input bcd_t d, input bcd_t lim);
    return (d <= lim);
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with load, clear-to-zero and borrow chaining.
// Ports:
//   clk      : system clock
//   clear    : synchronous active-high reset
//   zero     : force digit to 0
//   load     : load load_val
//   load_val : digit value to load
//   dec      : decrement this digit (already qualified by borrow-in)
//   q        : registered digit value
//   borrow_c : combinational borrow-out, digit is 0 and being decremented
module bcd_down_digit
  import irrigation_pkg::*;
#(
  parameter bcd_t WRAP = BCD_MAX_UNIT
) (
  input  logic clk,
  input  logic clear,
  input  logic zero,
  input  logic load,
  input  bcd_t load_val,
  input  logic dec,
  output bcd_t q,
  output logic borrow_c
);

  assign borrow_c = dec && (q == 4'd0);

  // Digit register; 0 wraps to WRAP on decrement.
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= 4'd0;
    end else if (zero) begin
      q <= 4'd0;
    end else if (load) begin
      q <= load_val;
    end else if (dec) begin
      q <= (q == 4'd0) ? WRAP : bcd_t'(q - 4'd1);
    end
  end

endmodule

// File: rtl/irrigation_timer.sv
// Countdown controller for one irrigation cycle (MM:SS BCD, 1 Hz tick).
// Optional feature macro: SOIL_SENSOR_EN (soil_wet aborts a run / blocks start).
// Ports:
//   clk, clear              : clock, synchronous active-high reset
//   tick                    : one-cycle pulse per second
//   start, pause, stop      : run control
//   dz_min..un_seg          : duration digits, sampled on accepted start
//   soil_wet                : moisture sensor
//   valve, busy, done, err  : registered status / valve enable
//   r_dz_min..r_un_seg      : registered remaining time
module irrigation_timer
  import irrigation_pkg::*;
#(
  parameter int unsigned MAX_DZ_MIN = 5
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic [3:0] dz_min,
  input  logic [3:0] un_min,
  input  logic [3:0] dz_seg,
  input  logic [3:0] un_seg,
  input  logic       soil_wet,
  output logic       valve,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] r_dz_min,
  output logic [3:0] r_un_min,
  output logic [3:0] r_dz_seg,
  output logic [3:0] r_un_seg
);

  // A tens-of-minutes limit above 9 still cannot exceed a legal BCD digit.
  localparam bcd_t DZ_MIN_LIM = (MAX_DZ_MIN > 9) ? BCD_MAX_UNIT : bcd_t'(MAX_DZ_MIN);

  state_t state, state_next;
  logic   load_c, zero_c, dec_c, err_c;
  logic   digits_valid, start_zero, last_sec;
  logic   soil_stop, soil_block;
  logic   b_un_seg, b_dz_seg, b_un_min, unused_borrow;

`ifdef SOIL_SENSOR_EN
  assign soil_stop  = soil_wet;
  assign soil_block = soil_wet;
`else
  logic unused_soil;
  assign unused_soil = soil_wet;
  assign soil_stop   = 1'b0;
  assign soil_block  = 1'b0;
`endif

  assign digits_valid = bcd_ok(dz_min, DZ_MIN_LIM)   && bcd_ok(un_min, BCD_MAX_UNIT) &&
                        bcd_ok(dz_seg, BCD_MAX_TENS) && bcd_ok(un_seg, BCD_MAX_UNIT);
  assign start_zero   = (dz_min == 4'd0) && (un_min == 4'd0) &&
                        (dz_seg == 4'd0) && (un_seg == 4'd0);
  // Count at 00:01: the next decrement finishes the cycle.
  assign last_sec     = (r_dz_min == 4'd0) && (r_un_min == 4'd0) &&
                        (r_dz_seg == 4'd0) && (r_un_seg == 4'd1);

  // State register.
  always_ff @(posedge clk) begin
    if (clear) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state and datapath controls; priority stop > tick > pause > start.
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    zero_c     = 1'b0;
    dec_c      = 1'b0;
    err_c      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!stop && start) begin
          if (!digits_valid || soil_block) begin
            err_c = 1'b1;
          end else if (start_zero) begin
            state_next = ST_DONE;
          end else begin
            load_c     = 1'b1;
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          zero_c     = 1'b1;
          state_next = ST_IDLE;
        end else if (soil_stop) begin
          zero_c     = 1'b1;
          state_next = ST_DONE;
        end else if (tick) begin
          dec_c = 1'b1;
          if (last_sec)   state_next = ST_DONE;
          else if (pause) state_next = ST_PAUSE;
        end else if (pause) begin
          state_next = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          zero_c     = 1'b1;
          state_next = ST_IDLE;
        end else if (start && !pause) begin
          state_next = ST_RUN;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Status outputs follow the state being entered.
  always_ff @(posedge clk) begin
    if (clear) begin
      valve <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      valve <= (state_next == ST_RUN);
      busy  <= (state_next == ST_RUN) || (state_next == ST_PAUSE);
      done  <= (state_next == ST_DONE);
      err   <= err_c;
    end
  end

  // Borrow chain: un_seg -> dz_seg -> un_min -> dz_min.
  bcd_down_digit #(.WRAP(BCD_MAX_UNIT)) u_un_seg (
    .clk(clk), .clear(clear), .zero(zero_c), .load(load_c), .load_val(un_seg),
    .dec(dec_c), .q(r_un_seg), .borrow_c(b_un_seg)
  );

  bcd_down_digit #(.WRAP(BCD_MAX_TENS)) u_dz_seg (
    .clk(clk), .clear(clear), .zero(zero_c), .load(load_c), .load_val(dz_seg),
    .dec(b_un_seg), .q(r_dz_seg), .borrow_c(b_dz_seg)
  );

  bcd_down_digit #(.WRAP(BCD_MAX_UNIT)) u_un_min (
    .clk(clk), .clear(clear), .zero(zero_c), .load(load_c), .load_val(un_min),
    .dec(b_dz_seg), .q(r_un_min), .borrow_c(b_un_min)
  );

  // Never borrows in practice: a running count is always nonzero.
  bcd_down_digit #(.WRAP(BCD_MAX_UNIT)) u_dz_min (
    .clk(clk), .clear(clear), .zero(zero_c), .load(load_c), .load_val(dz_min),
    .dec(b_un_min), .q(r_dz_min), .borrow_c(unused_borrow)
  );

endmodule
